// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core.
// Imported by stopwatch_core and bcd_mod60.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      ADJ  = 2'd2
   } sw_state_t;

   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;

   localparam logic SEL_SEC = 1'b0;
   localparam logic SEL_MIN = 1'b1;

   function automatic int max2(int a, int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter wrapping at MAX_VAL.
// clr beats inc; carry flags an increment taken at the top value.
module bcd_mod60
   import stopwatch_pkg::*;
#(
   parameter int MAX_VAL = SEC_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       carry
);

   localparam logic [3:0] TENS_TOP = 4'(MAX_VAL / 10);
   localparam logic [3:0] ONES_TOP = 4'(MAX_VAL % 10);

   logic [3:0] tens_q;
   logic [3:0] tens_d;
   logic [3:0] ones_q;
   logic [3:0] ones_d;
   logic       at_top;

   assign at_top = (tens_q == TENS_TOP) && (ones_q == ONES_TOP);
   assign carry  = inc & at_top;

   // next digit values: clear, wrap at top, ones->tens rollover
   always_comb begin
      tens_d = tens_q;
      ones_d = ones_q;
      if (clr) begin
         tens_d = '0;
         ones_d = '0;
      end else if (inc) begin
         if (at_top) begin
            tens_d = '0;
            ones_d = '0;
         end else if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end
   end

   // digit registers
   always_ff @(posedge clk) begin
      if (rst) begin
         tens_q <= '0;
         ones_q <= '0;
      end else begin
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign tens = tens_q;
   assign ones = ones_q;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch fed by the divider square wave.
// Edge detect, prescaler and run/stop/adjust FSM.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_SEC = 10000,
   parameter int ADJ_TICKS     = 5000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       div_in,
   input  logic       start_stop,
   input  logic       clr,
   input  logic       adj_en,
   input  logic       adj_sel,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       wrap
);

   localparam int TMAX = max2(TICKS_PER_SEC, ADJ_TICKS);
   localparam int PW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [PW-1:0] RUN_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [PW-1:0] ADJ_LAST = PW'(ADJ_TICKS - 1);

   sw_state_t   state_q;
   logic        div_q;
   logic        div_edge;
   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;
   logic [PW-1:0] pre_last;
   logic        step;
   logic        adj_chg;
   logic        in_run;
   logic        in_adj;
   logic        sec_inc;
   logic        min_inc;
   logic        sec_carry;
   logic        min_carry;
   logic        running_q;
   logic        wrap_q;
   logic        wrap_d;

   assign div_edge = div_in & ~div_q;
   assign in_run   = (state_q == RUN);
   assign in_adj   = (state_q == ADJ);

   // ADJ is entered/left exactly when adj_en disagrees with the state
   assign adj_chg  = adj_en ^ in_adj;

   // divider sample; starts high so a high input after reset is no edge
   always_ff @(posedge clk) begin
      if (rst) div_q <= 1'b1;
      else     div_q <= div_in;
   end

   // prescaler: counts edges outside STOP, restarts on ADJ change or clr
   always_comb begin
      pre_last = in_adj ? ADJ_LAST : RUN_LAST;
      pre_d    = pre_q;
      step     = 1'b0;
      if (div_edge && (state_q != STOP)) begin
         if (pre_q == pre_last) begin
            step  = 1'b1;
            pre_d = '0;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
      if (adj_chg || clr) pre_d = '0;
   end

   // prescaler register
   always_ff @(posedge clk) begin
      if (rst) pre_q <= '0;
      else     pre_q <= pre_d;
   end

   assign sec_inc = step & (in_run | (in_adj & (adj_sel == SEL_SEC)));
   assign min_inc = step & ((in_run & sec_carry)
                   | (in_adj & (adj_sel == SEL_MIN)));
   assign wrap_d  = step & in_run & sec_carry & min_carry & ~clr;

   // run/stop/adjust state with registered running and wrap
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= STOP;
         running_q <= 1'b0;
         wrap_q    <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
         unique case (state_q)
            STOP: begin
               if (adj_en) begin
                  state_q <= ADJ;
               end else if (start_stop) begin
                  state_q   <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               if (adj_en) begin
                  state_q   <= ADJ;
                  running_q <= 1'b0;
               end else if (start_stop) begin
                  state_q   <= STOP;
                  running_q <= 1'b0;
               end
            end
            ADJ: begin
               if (!adj_en) state_q <= STOP;
            end
            default: begin
               state_q   <= STOP;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   bcd_mod60 #(
      .MAX_VAL(SEC_MAX)
   ) u_sec (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (sec_inc),
      .tens (sec_tens),
      .ones (sec_ones),
      .carry(sec_carry)
   );

   bcd_mod60 #(
      .MAX_VAL(MIN_MAX)
   ) u_min (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .inc  (min_inc),
      .tens (min_tens),
      .ones (min_ones),
      .carry(min_carry)
   );

   assign running = running_q;
   assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random
// stimulus, checked every cycle against a seconds-based model.
module tb_stopwatch_core;

   localparam int TPS  = 4;
   localparam int ADJT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       div_in = 1'b0;
   logic       start_stop = 1'b0;
   logic       clr = 1'b0;
   logic       adj_en = 1'b0;
   logic       adj_sel = 1'b0;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       wrap;

   always #5 clk = ~clk;

   stopwatch_core #(
      .TICKS_PER_SEC(TPS),
      .ADJ_TICKS    (ADJT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .div_in    (div_in),
      .start_stop(start_stop),
      .clr       (clr),
      .adj_en    (adj_en),
      .adj_sel   (adj_sel),
      .min_tens  (min_tens),
      .min_ones  (min_ones),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .running   (running),
      .wrap      (wrap)
   );

   int n_checks = 0;
   int n_errors = 0;

   // model: plain minutes/seconds, edges seen since last step
   int m_min = 0;
   int m_sec = 0;
   int m_pre = 0;
   int m_st = 0;   // 0 stopped, 1 running, 2 adjusting
   bit m_divq = 1'b1;
   bit m_run = 1'b0;
   bit m_wrap = 1'b0;
   int m_edges = 0;

   bit gen_on = 1'b1;
   int gen_cnt = 0;
   bit rise_next = 1'b0;
   int wrap_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] bcd(input int mm, input int ss);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic model_step();
      bit e;
      bit step;
      int nxt;
      int lim;
      int t;
      if (rst) begin
         m_min = 0; m_sec = 0; m_pre = 0; m_st = 0;
         m_divq = 1'b1; m_run = 1'b0; m_wrap = 1'b0;
         return;
      end
      e = div_in && !m_divq;
      m_divq = div_in;
      if (e) m_edges++;
      if (adj_en) nxt = 2;
      else if (m_st == 2) nxt = 0;
      else if (start_stop) nxt = (m_st == 1) ? 0 : 1;
      else nxt = m_st;
      lim = (m_st == 2) ? ADJT : TPS;
      step = 1'b0;
      if (m_st != 0 && e) begin
         m_pre++;
         if (m_pre >= lim) begin
            m_pre = 0;
            step = 1'b1;
         end
      end
      if ((m_st == 2) != (nxt == 2)) m_pre = 0;
      m_wrap = 1'b0;
      if (clr) begin
         m_min = 0; m_sec = 0; m_pre = 0;
      end else if (step) begin
         if (m_st == 1) begin
            t = m_min * 60 + m_sec + 1;
            if (t == 3600) begin
               t = 0;
               m_wrap = 1'b1;
            end
            m_min = t / 60;
            m_sec = t % 60;
         end else if (adj_sel) begin
            m_min = (m_min + 1) % 60;
         end else begin
            m_sec = (m_sec + 1) % 60;
         end
      end
      m_st = nxt;
      m_run = (m_st == 1);
   endtask

   task automatic cyc();
      logic prev;
      @(posedge clk);
      model_step();
      #1;
      chk("digits", {min_tens, min_ones, sec_tens, sec_ones},
          bcd(m_min, m_sec));
      chk("running", running, m_run);
      chk("wrap", wrap, m_wrap);
      if (wrap === 1'b1) wrap_cnt++;
      prev = div_in;
      if (gen_on) begin
         gen_cnt++;
         if (gen_cnt == 5) begin
            gen_cnt = 0;
            div_in = ~div_in;
         end
      end
      rise_next = div_in && !prev;
   endtask

   task automatic edges(input int n);
      int tgt;
      int b;
      tgt = m_edges + n;
      b = 0;
      while (m_edges < tgt && b < 20 * n + 40) begin
         cyc();
         b++;
      end
      if (m_edges < tgt) chk("edge_timeout", m_edges, tgt);
   endtask

   // keep control changes off cycles that carry a divider edge
   task automatic quiet();
      int b;
      b = 0;
      while (rise_next && b < 4) begin
         cyc();
         b++;
      end
   endtask

   task automatic pulse_ss();
      quiet();
      start_stop = 1'b1;
      cyc();
      start_stop = 1'b0;
   endtask

   task automatic adj_to(input bit sel, input int target);
      int b;
      quiet();
      adj_en = 1'b1;
      adj_sel = sel;
      b = 0;
      while (((sel ? m_min : m_sec) != target) && b < 200) begin
         edges(1);
         b++;
      end
      chk("adj_target", sel ? m_min : m_sec, target);
   endtask

   task automatic leave_adj();
      quiet();
      adj_en = 1'b0;
      cyc();
   endtask

   initial begin
      int b;
      repeat (3) cyc();
      rst = 1'b0;
      chk("rst_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0);
      chk("rst_running", running, 1'b0);
      chk("rst_wrap", wrap, 1'b0);

      edges(20);
      chk("stop_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0);
      chk("stop_running", running, 1'b0);
      pulse_ss();
      edges(8);
      chk("run_8_edges", {min_tens, min_ones, sec_tens, sec_ones},
          16'h0002);
      chk("run_running", running, 1'b1);

      quiet();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_keeps_run", running, 1'b1);
      adj_to(1'b0, 59);
      leave_adj();
      pulse_ss();
      edges(4);
      chk("sec_carry", {min_tens, min_ones, sec_tens, sec_ones},
          16'h0100);

      adj_to(1'b0, 59);
      adj_to(1'b1, 59);
      leave_adj();
      pulse_ss();
      wrap_cnt = 0;
      edges(4);
      chk("rollover", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0);
      chk("wrap_now", wrap, 1'b1);
      cyc();
      chk("wrap_single", wrap_cnt, 1);

      edges(2);
      pulse_ss();
      edges(10);
      chk("pause_hold", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0);
      pulse_ss();
      edges(1);
      chk("resume_1", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0);
      edges(1);
      chk("resume_2", {min_tens, min_ones, sec_tens, sec_ones},
          16'h0001);

      adj_to(1'b1, 7);
      adj_to(1'b0, 58);
      wrap_cnt = 0;
      edges(4);
      chk("adj_sec_wrap", {min_tens, min_ones, sec_tens, sec_ones},
          16'h0700);
      chk("adj_no_wrap", wrap_cnt, 0);
      leave_adj();
      edges(4);
      chk("adj_exit_stop", {min_tens, min_ones, sec_tens, sec_ones},
          16'h0700);
      chk("adj_exit_run", running, 1'b0);

      adj_to(1'b1, 59);
      adj_to(1'b0, 59);
      leave_adj();
      pulse_ss();
      edges(3);
      b = 0;
      while (!rise_next && b < 20) begin
         cyc();
         b++;
      end
      wrap_cnt = 0;
      clr = 1'b1;
      cyc();
      clr = 1'b0;
      chk("clr_vs_step", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0);
      chk("clr_no_wrap", wrap_cnt, 0);
      chk("clr_run_kept", running, 1'b1);

      adj_to(1'b1, 12);
      adj_to(1'b0, 34);
      leave_adj();
      pulse_ss();
      chk("pre_rst_time", {min_tens, min_ones, sec_tens, sec_ones},
          16'h1234);
      gen_on = 1'b0;
      div_in = 1'b1;
      rst = 1'b1;
      cyc();
      chk("mid_rst_digits", {min_tens, min_ones, sec_tens, sec_ones},
          16'h0);
      chk("mid_rst_running", running, 1'b0);
      rst = 1'b0;
      pulse_ss();
      repeat (3) cyc();
      chk("rst_high_div", {min_tens, min_ones, sec_tens, sec_ones},
          16'h0);

      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom % 500) == 0;
         start_stop = ($urandom % 10) == 0;
         clr = ($urandom % 150) == 0;
         if (($urandom % 80) == 0) adj_en = ~adj_en;
         if (adj_en && ($urandom % 40) == 0) adj_en = 1'b0;
         if (($urandom % 16) == 0) adj_sel = ~adj_sel;
         if (($urandom % 3) == 0) div_in = ~div_in;
         cyc();
      end
      rst = 1'b0;
      start_stop = 1'b0;
      clr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Time-keeping stage directly downstream of the 10 kHz frequency divider. It samples the divider's square-wave output in the system clock domain and edge-detects it into single-cycle ticks. It prescales those ticks to 1 Hz and maintains an MM:SS BCD count with run/pause, clear and manual-adjust modes. Its digit outputs feed the seven-segment display driver.

## Interface
- `TICKS_PER_SEC`, default 10000: divider rising edges per counted second.
- `ADJ_TICKS`, default 5000: divider rising edges per adjust increment (2 Hz).
- `clk`  in  1  system clock (100 MHz); the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `div_in`  in  1  divider output; square wave synchronous to `clk`, so no synchronizer.
- `start_stop`  in  1  one-cycle pulse; toggles between RUN and STOP.
- `clr`  in  1  one-cycle pulse; zeroes the time.
- `adj_en`  in  1  level; high selects adjust mode.
- `adj_sel`  in  1  adjust target: 0 = seconds, 1 = minutes.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits, registered.
- `running`  out  1  high while in RUN.
- `wrap`  out  1  one-cycle pulse on the 59:59 -> 00:00 rollover.

## Operation
- Edge detect: `div_q` registers `div_in`; `edge = div_in & ~div_q`. `div_q` resets to 1, so a high `div_in` on the first post-reset cycle does not produce an edge.
- Prescaler `pre` counts edges from 0 to LIMIT-1.
  - LIMIT is `TICKS_PER_SEC` in RUN and `ADJ_TICKS` in ADJ.
  - Width is `$clog2(max(TICKS_PER_SEC, ADJ_TICKS))`.
  - An edge with `pre == LIMIT-1` produces a step and sets `pre` to 0.
- States are STOP, RUN and ADJ.
  - Reset enters STOP.
  - STOP -> RUN on `start_stop`.
  - RUN -> STOP on `start_stop`.
  - STOP or RUN -> ADJ whenever `adj_en == 1`; this has priority over `start_stop` in the same cycle.
  - ADJ -> STOP when `adj_en == 0`.
  - `start_stop` is ignored while in ADJ.
- Prescaler by state:
  - STOP: `pre` holds, so a pause preserves the fractional second.
  - Entering or leaving ADJ clears `pre` to 0.
- Step in RUN: seconds increment. At 59 seconds they wrap to 0 and carry into minutes. At 59 minutes the minutes wrap to 0 and `wrap` pulses.
- Step in ADJ: only the field selected by `adj_sel` increments. It wraps 59 -> 0 with no carry, and `wrap` does not pulse.
- Each field is a two-digit BCD counter: ones 0-9, tens 0-5. No non-BCD value is ever produced.
- `clr`:
  - Zeroes all digits and `pre` in any state.
  - Does not change the state; RUN continues from 00:00.
  - Wins over a step in the same cycle (result is 00:00, no `wrap`).
- Reset values: all digits 0, `pre` = 0, `div_q` = 1, `running` = 0, `wrap` = 0.

## Timing
- If `div_in` first reads high in cycle n, `edge` is asserted in cycle n.
- A step caused by that edge is visible on the digits and on `wrap` in cycle n+1, a latency of 1 clock.
- `running` is registered from the state and is high in the same cycle the state register holds RUN.
- A `start_stop` pulse in cycle n gives the new state in cycle n+1. An edge in cycle n is evaluated under the old state.
- `adj_en` and `adj_sel` are sampled every cycle. Changing `adj_sel` mid-interval does not clear `pre`.
- Mid-operation `rst` overrides everything on that clock edge, including `clr` and `edge`.

## Structure
- Shared package `stopwatch_pkg`:
  - state enum `sw_state_t` (STOP, RUN, ADJ);
  - constants `SEC_MAX = 59` and `MIN_MAX = 59`;
  - the `adj_sel` encodings `SEL_SEC` and `SEL_MIN`.
- One sub-module, `bcd_mod60`, instantiated twice (seconds and minutes).
  - Inputs: `clk`, `rst`, `clr`, `inc`.
  - Outputs: `tens[3:0]`, `ones[3:0]`, `carry` (combinational; high when `inc` is asserted and the value is 59).
- Edge detect, prescaler and FSM live in `stopwatch_core`.

## Test plan
All scenarios use `TICKS_PER_SEC` = 4 and `ADJ_TICKS` = 2, with `div_in` toggling every 5 clocks.
- Reset, then 20 edges in STOP -> digits stay 00:00 and `running` stays 0. Pulse `start_stop`, then 8 edges -> 00:02 and `running` = 1.
- Preload 00:59 via ADJ. In RUN, drive 4 edges -> 01:00. Preload 59:59 and drive 4 edges -> 00:00 with a single-cycle `wrap`.
- RUN with `pre` = 2, pulse `start_stop`, drive 10 edges -> time unchanged. Resume; the second increments after exactly 2 further edges.
- `adj_en` = 1, `adj_sel` = 0, seconds at 58, drive 4 edges -> 00 with minutes unchanged and no `wrap`. Drop `adj_en` -> state is STOP.
- `clr` asserted in the same cycle as a stepping edge at 59:59 -> 00:00 with `wrap` = 0, and RUN is retained.
- Assert `rst` mid-RUN at 12:34 -> next cycle shows 00:00 with `running` = 0. `div_in` held high across reset yields no edge.
